// File: rtl/nibble_packer.sv
// nibble_packer: pairs 4-bit nibbles from a valid/ready stream into 8-bit words
// and presents each word on a registered valid/ready output.
module nibble_packer #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       half_pending
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_data;

  logic       w_in_beat;
  logic       w_out_beat;
  logic [7:0] w_first_word;
  logic [7:0] w_second_word;

  assign in_ready   = !clr && ((r_state != FULL) || out_ready);
  assign w_in_beat  = in_valid && in_ready;
  assign w_out_beat = (r_state == FULL) && out_ready;

  // Opening a word always zeroes the other slot so a half word never shows stale data.
  assign w_first_word  = LOW_FIRST ? {4'h0, in_data} : {in_data, 4'h0};
  assign w_second_word = LOW_FIRST ? {in_data, r_data[3:0]} : {r_data[7:4], in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= 8'h00;
    end else if (clr) begin
      r_state <= EMPTY;
      r_data  <= 8'h00;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_beat) begin
            r_data  <= w_first_word;
            r_state <= HALF;
          end
        end
        HALF: begin
          if (w_in_beat) begin
            r_data  <= w_second_word;
            r_state <= FULL;
          end
        end
        FULL: begin
          // An input beat here implies an output beat, since in_ready follows out_ready.
          if (w_out_beat) begin
            if (w_in_beat) begin
              r_data  <= w_first_word;
              r_state <= HALF;
            end else begin
              r_state <= EMPTY;
            end
          end
        end
        default: begin
          r_state <= EMPTY;
          r_data  <= 8'h00;
        end
      endcase
    end
  end

  assign out_data     = r_data;
  assign out_valid    = (r_state == FULL);
  assign half_pending = (r_state == HALF);

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed checks of both nibble orderings driven by a shared stimulus.
module tb_nibble_packer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [3:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       lo_in_ready, lo_out_valid, lo_half;
  logic [7:0] lo_out_data;
  logic       hi_in_ready, hi_out_valid, hi_half;
  logic [7:0] hi_out_data;

  int checks   = 0;
  int failures = 0;
  int loBeats  = 0;

  nibble_packer #(.LOW_FIRST(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(lo_in_ready),
    .out_data(lo_out_data), .out_valid(lo_out_valid), .out_ready(out_ready),
    .half_pending(lo_half)
  );

  nibble_packer #(.LOW_FIRST(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(hi_in_ready),
    .out_data(hi_out_data), .out_valid(hi_out_valid), .out_ready(out_ready),
    .half_pending(hi_half)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delivered words of the LOW_FIRST=1 instance; a clr or reset edge delivers nothing.
  always @(posedge clk) begin
    if (rst_n && !clr && lo_out_valid && out_ready) loBeats++;
  end

  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr       = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic v, input logic h);
    checkOutput({tag, "_lo_valid"}, {7'd0, lo_out_valid}, {7'd0, v});
    checkOutput({tag, "_lo_half"},  {7'd0, lo_half},      {7'd0, h});
    checkOutput({tag, "_hi_valid"}, {7'd0, hi_out_valid}, {7'd0, v});
    checkOutput({tag, "_hi_half"},  {7'd0, hi_half},      {7'd0, h});
  endtask

  int beatsBefore;
  logic [7:0] streamWords [3];

  initial begin
    streamWords[0] = 8'h21;
    streamWords[1] = 8'h43;
    streamWords[2] = 8'h65;

    // Asynchronous reset before any clock edge.
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    #2;
    checkFlags("reset", 1'b0, 1'b0);
    checkOutput("reset_lo_data", lo_out_data, 8'h00);
    checkOutput("reset_hi_data", hi_out_data, 8'h00);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", {7'd0, lo_in_ready}, 8'd1);
    tick();

    // Basic pair A then 5.
    applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
    tick();
    checkFlags("pair1", 1'b0, 1'b1);
    checkOutput("pair1_lo_data", lo_out_data, 8'h0A);
    checkOutput("pair1_hi_data", hi_out_data, 8'hA0);
    applyStimulus(1'b1, 4'h5, 1'b1, 1'b0);
    tick();
    checkFlags("pair2", 1'b1, 1'b0);
    checkOutput("pair2_lo_data", lo_out_data, 8'h5A);
    checkOutput("pair2_hi_data", hi_out_data, 8'hA5);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    checkFlags("pair3", 1'b0, 1'b0);
    checkOutput("pair3_lo_hold", lo_out_data, 8'h5A);
    checkOutput("pair_beats", loBeats[7:0], 8'd1);

    // Backpressure on a held word.
    applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h5, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    #1;
    checkOutput("bp_in_ready", {7'd0, lo_in_ready}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkFlags("bp_hold", 1'b1, 1'b0);
      checkOutput("bp_lo_data", lo_out_data, 8'h5A);
      checkOutput("bp_in_ready_hold", {7'd0, lo_in_ready}, 8'd0);
    end
    applyStimulus(1'b1, 4'h3, 1'b1, 1'b0);
    #1;
    checkOutput("bp_release_ready", {7'd0, lo_in_ready}, 8'd1);
    tick();
    checkFlags("bp_release", 1'b0, 1'b1);
    checkOutput("bp_release_lo", lo_out_data, 8'h03);
    checkOutput("bp_release_hi", hi_out_data, 8'h30);
    checkOutput("bp_beats", loBeats[7:0], 8'd2);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

    // Streaming nibbles 1..6 with continuous handshakes.
    beatsBefore = loBeats;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, k[3:0], 1'b1, 1'b0);
      tick();
      if (k % 2 == 0) begin
        checkFlags("stream_full", 1'b1, 1'b0);
        checkOutput("stream_word", lo_out_data, streamWords[k/2 - 1]);
      end else begin
        checkFlags("stream_half", 1'b0, 1'b1);
      end
    end
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    checkFlags("stream_end", 1'b0, 1'b0);
    checkOutput("stream_beats", 8'(loBeats - beatsBefore), 8'd3);

    // clr in HALF.
    applyStimulus(1'b1, 4'hC, 1'b1, 1'b0);
    tick();
    checkOutput("clrh_lo_data", lo_out_data, 8'h0C);
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b1);
    #1;
    checkOutput("clrh_in_ready", {7'd0, lo_in_ready}, 8'd0);
    tick();
    checkFlags("clrh", 1'b0, 1'b0);
    checkOutput("clrh_lo_zero", lo_out_data, 8'h00);
    checkOutput("clrh_hi_zero", hi_out_data, 8'h00);

    // clr in FULL with the consumer ready: word dropped.
    applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    tick();
    checkOutput("clrf_pre", lo_out_data, 8'h5A);
    beatsBefore = loBeats;
    applyStimulus(1'b1, 4'h9, 1'b1, 1'b1);
    #1;
    checkOutput("clrf_in_ready", {7'd0, lo_in_ready}, 8'd0);
    tick();
    checkFlags("clrf", 1'b0, 1'b0);
    checkOutput("clrf_lo_zero", lo_out_data, 8'h00);
    checkOutput("clrf_beats", 8'(loBeats - beatsBefore), 8'd0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

    // Reset mid-word in HALF, then in FULL.
    applyStimulus(1'b1, 4'hC, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkFlags("rsth", 1'b0, 1'b0);
    checkOutput("rsth_lo_zero", lo_out_data, 8'h00);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    tick();
    checkOutput("rstf_pre", lo_out_data, 8'h5A);
    beatsBefore = loBeats;
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkFlags("rstf", 1'b0, 1'b0);
    checkOutput("rstf_lo_zero", lo_out_data, 8'h00);
    checkOutput("rstf_hi_zero", hi_out_data, 8'h00);
    rst_n = 1'b1;
    tick();
    checkOutput("rstf_beats", 8'(loBeats - beatsBefore), 8'd0);
    checkOutput("rstf_in_ready", {7'd0, lo_in_ready}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
